// File: rtl/simple_risc_pkg.sv
// Shared Simple RISC memory-interface definitions: bus widths, responder FSM states
// and the word-index width helper.
package simple_risc_pkg;

  localparam int SR_DATA_W = 32;
  localparam int SR_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response bus. rsp_err exists only when
// DMEM_RANGE_CHECK_EN is defined.
interface dmem_responder_if import simple_risc_pkg::*; #(
  parameter int DATA_W = SR_DATA_W,
  parameter int ADDR_W = SR_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
`ifdef DMEM_RANGE_CHECK_EN
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, busy, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, busy, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port data RAM: synchronous write, read data follows the index so the
// responder can capture it on the same edge as the access.
module dmem_array import simple_risc_pkg::*; #(
  parameter int DATA_W = SR_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, registered response.
// Optional DMEM_RANGE_CHECK_EN adds out-of-range detection and the rsp_err output.
module dmem_responder import simple_risc_pkg::*; #(
  parameter int DATA_W      = SR_DATA_W,
  parameter int ADDR_W      = SR_ADDR_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            Clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W     = idx_width(DEPTH);
  // Counter runs WAIT_CYCLES-1 .. 0 so the access lands WAIT_CYCLES edges after accept.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
    $error("dmem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
  end

  dmem_state_e       state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              busy_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              access;
  logic              acc_we;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rsp_data;
  logic              addr_unused;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  assign access = !reset && (((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                             (accept && (WAIT_CYCLES == 0)));

  // With zero wait states the access happens on the accept edge, straight from the bus.
  assign acc_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_err     = |acc_addr[ADDR_W-1:IDX_W+2];
  assign addr_unused = ^acc_addr[1:0];
  assign bus.rsp_err = err_q;
`else
  assign acc_err     = 1'b0;
  assign addr_unused = ^{acc_addr[ADDR_W-1:IDX_W+2], acc_addr[1:0], err_q};
`endif

  assign rsp_data = (acc_we || acc_err) ? '0 : ram_rdata;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (access && acc_we && !acc_err),
    .idx_i   (acc_addr[IDX_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= WAIT_LOAD;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= rsp_data;
              err_q       <= acc_err;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rsp_data;
            err_q       <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked against a
// word-addressed reference memory with expected latency WAIT_CYCLES+1.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int W_A   = 2;
  localparam int W_B   = 0;

  logic        Clk;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        o_req_ready, o_rsp_valid, o_busy;
  logic [31:0] o_rsp_rdata;
`ifdef DMEM_RANGE_CHECK_EN
  logic        o_rsp_err;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_accept = 0;

  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];

  dmem_responder_if if_a ();
  dmem_responder_if if_b ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_A)) u_dut_a (.Clk(Clk), .reset(reset), .bus(if_a));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_B)) u_dut_b (.Clk(Clk), .reset(reset), .bus(if_b));

  assign if_a.req_valid = req_valid & sel;
  assign if_b.req_valid = req_valid & ~sel;
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;
  assign if_a.rsp_ready = rsp_ready;
  assign if_b.rsp_ready = rsp_ready;

  assign o_req_ready = sel ? if_a.req_ready : if_b.req_ready;
  assign o_rsp_valid = sel ? if_a.rsp_valid : if_b.rsp_valid;
  assign o_rsp_rdata = sel ? if_a.rsp_rdata : if_b.rsp_rdata;
  assign o_busy      = sel ? if_a.busy      : if_b.busy;
`ifdef DMEM_RANGE_CHECK_EN
  assign o_rsp_err   = sel ? if_a.rsp_err   : if_b.rsp_err;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference memory: one word per (addr/4) mod DEPTH; out-of-range addresses error out when checked.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int idx;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
    err = ((addr >> 2) >= DEPTH);
`else
    err = 1'b0;
`endif
    rdata = 32'd0;
    if (err) return;
    if (we) begin
      if (sel) mem_a[idx] = wdata;
      else     mem_b[idx] = wdata;
    end else if (sel) begin
      rdata = mem_a.exists(idx) ? mem_a[idx] : 'x;
    end else begin
      rdata = mem_b.exists(idx) ? mem_b[idx] : 'x;
    end
  endfunction

  function automatic int exp_lat();
    return (sel ? W_A : W_B) + 1;
  endfunction

  // Caller is at a negedge; hold = cycles rsp_ready is kept low once rsp_valid is seen.
  task automatic do_txn(input string nm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic [31:0] exp_d, held;
    logic        exp_e;
    int          lat, waitc;
    model_access(we, addr, wdata, exp_d, exp_e);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    waitc = 0;
    while (!o_req_ready && waitc < 20) begin @(negedge Clk); waitc++; end
    tests++;
    if (o_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_accept: req_ready=%b required 1", nm, o_req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    last_accept = cyc;
    @(negedge Clk);
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin @(negedge Clk); lat++; end
    tests++;
    if (lat !== exp_lat()) begin
      fails++; $display("FAIL %s_latency: got %0d cycles required %0d", nm, lat, exp_lat());
    end
    tests++;
    if (o_rsp_rdata !== exp_d) begin
      fails++; $display("FAIL %s_rdata: got %h required %h", nm, o_rsp_rdata, exp_d);
    end
`ifdef DMEM_RANGE_CHECK_EN
    tests++;
    if (o_rsp_err !== exp_e) begin
      fails++; $display("FAIL %s_err: got %b required %b", nm, o_rsp_err, exp_e);
    end
`endif
    held = o_rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      tests++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== held || o_req_ready !== 1'b0 || o_busy !== 1'b1) begin
        fails++;
        $display("FAIL %s_hold%0d: valid=%b rdata=%h ready=%b busy=%b required 1 %h 0 1",
                 nm, i, o_rsp_valid, o_rsp_rdata, o_req_ready, o_busy, held);
      end
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    tests++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0 || o_rsp_rdata !== exp_d) begin
      fails++;
      $display("FAIL %s_done: valid=%b ready=%b busy=%b rdata=%h required 0 1 0 %h",
               nm, o_rsp_valid, o_req_ready, o_busy, o_rsp_rdata, exp_d);
    end
  endtask

  task automatic check_idle_after_reset(input string nm);
    tests++;
    if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== 32'd0) begin
      fails++;
      $display("FAIL %s: valid=%b busy=%b ready=%b rdata=%h required 0 0 1 00000000",
               nm, o_rsp_valid, o_busy, o_req_ready, o_rsp_rdata);
    end
`ifdef DMEM_RANGE_CHECK_EN
    tests++;
    if (o_rsp_err !== 1'b0) begin
      fails++; $display("FAIL %s_err: got %b required 0", nm, o_rsp_err);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    sel = 1'b1; check_idle_after_reset("reset_a");
    sel = 1'b0; check_idle_after_reset("reset_b");
  endtask

  task automatic test_basic();
    sel = 1'b1;
    do_txn("t1_store", 1'b1, 32'h10, 32'hCAFE_F00D, 0);
    do_txn("t1_load",  1'b0, 32'h10, 32'h0, 0);
    do_txn("t1_misaligned_load", 1'b0, 32'h13, 32'h0, 1);
  endtask

  task automatic test_zero_wait();
    sel = 1'b0;
    do_txn("t2_store", 1'b1, 32'h0, 32'h0000_1234, 0);
    do_txn("t2_load",  1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    int first;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_txn("b2b_st", 1'b1, 32'h80, 32'h600D_0000 + s, 0);
      first = last_accept;
      do_txn("b2b_ld", 1'b0, 32'h80, 32'h0, 0);
      tests++;
      if (last_accept - first !== exp_lat() + 1) begin
        fails++;
        $display("FAIL b2b_spacing_sel%0d: got %0d cycles required %0d", s, last_accept - first, exp_lat() + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_d, held;
    logic        exp_e;
    int          lat;
    sel = 1'b1;
    model_access(1'b0, 32'h10, 32'h0, exp_d, exp_e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge Clk); @(negedge Clk);
    // Second request presented at once and held through WAIT and the stalled RESP.
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BAD_BEEF;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin @(negedge Clk); lat++; end
    tests++;
    if (lat !== exp_lat() || o_rsp_rdata !== exp_d) begin
      fails++; $display("FAIL t3_first: lat=%0d rdata=%h required %0d %h", lat, o_rsp_rdata, exp_lat(), exp_d);
    end
    held = o_rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      tests++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== held || o_req_ready !== 1'b0) begin
        fails++;
        $display("FAIL t3_stall%0d: valid=%b rdata=%h ready=%b required 1 %h 0", i, o_rsp_valid, o_rsp_rdata, o_req_ready, held);
      end
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    tests++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      fails++; $display("FAIL t3_release: valid=%b ready=%b required 0 1", o_rsp_valid, o_req_ready);
    end
    model_access(1'b1, 32'h40, 32'h0BAD_BEEF, exp_d, exp_e);
    @(posedge Clk); @(negedge Clk);
    req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin @(negedge Clk); lat++; end
    tests++;
    if (lat !== exp_lat() || o_rsp_rdata !== 32'd0) begin
      fails++; $display("FAIL t3_second: lat=%0d rdata=%h required %0d 00000000", lat, o_rsp_rdata, exp_lat());
    end
    @(negedge Clk);
    do_txn("t3_readback", 1'b0, 32'h40, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    sel = 1'b1;
    do_txn("t4_pre", 1'b1, 32'h20, 32'h1357_9BDF, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA_5555; rsp_ready = 1'b1;
    @(posedge Clk); @(negedge Clk);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    check_idle_after_reset("t4_wait_reset");
    repeat (4) @(negedge Clk);
    tests++;
    if (o_rsp_valid !== 1'b0) begin
      fails++; $display("FAIL t4_no_late_rsp: valid=%b required 0", o_rsp_valid);
    end
    do_txn("t4_load_old", 1'b0, 32'h20, 32'h0, 0);
    // Reset while the response of a committed store is stalled.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h5A5A_A5A5; rsp_ready = 1'b0;
    @(posedge Clk); @(negedge Clk);
    req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin @(negedge Clk); lat++; end
    tests++;
    if (o_rsp_valid !== 1'b1) begin
      fails++; $display("FAIL t4_resp_seen: valid=%b required 1", o_rsp_valid);
    end
    model_access(1'b1, 32'h24, 32'h5A5A_A5A5, exp_d, exp_e);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    check_idle_after_reset("t4_resp_reset");
    do_txn("t4_load_committed", 1'b0, 32'h24, 32'h0, 0);
  endtask

  task automatic test_range();
    sel = 1'b1;
    do_txn("t5_pre",   1'b1, 32'h0,    32'h0F0F_0F0F, 0);
    do_txn("t5_oob",   1'b1, 32'h1000, 32'hDEAD_BEEF, 0);
    do_txn("t5_load0", 1'b0, 32'h0,    32'h0, 0);
    do_txn("t5_oob_ld", 1'b0, 32'h8000_0010, 32'h0, 0);
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 8; k++) do_txn("rnd_fill", 1'b1, 32'h200 + 4 * k, $urandom, 0);
    end
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 1);
      we   = $urandom_range(0, 1);
      addr = 32'h200 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      do_txn("rnd", we, addr, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    sel = 1'b1; reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_wait();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
